tqvp_htfab_nco_quad: RTL and testbench

Four-channel numerically controlled oscillator peripheral on the TinyQV peripheral register bus. It sits directly behind the SPI test harness / CPU bus, which drives address, data_in and the write/read strobes and consumes data_out and data_ready. Each channel is a phase accumulator producing a square wave and a divide-by-2 wrap toggle on uo_out; channel 0 wraps can raise user_interrupt.

---
 rtl/tqvp_htfab_nco_quad.sv | 150 +++++++++++++++
 tb/tb_tqvp_htfab_nco_quad.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_htfab_nco_quad.sv
// Four-channel phase-accumulator NCO on the TinyQV peripheral bus.
// Square outputs on uo_out[3:0], divide-by-2 wrap toggles on uo_out[7:4].
module tqvp_htfab_nco_quad #(
  parameter int ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic [10:0]           ctrl_q, ctrl_d;
  logic [3:0][ACC_W-1:0] freq_q, freq_d;
  logic [3:0][ACC_W-1:0] acc_q, acc_d;
  logic [3:0]            toggle_q, toggle_d;
  logic [3:0]            uo_lo_q, uo_lo_d;
  logic [15:0]           wrapcnt_q, wrapcnt_d;
  logic                  pending_q, pending_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  data_ready_q, data_ready_d;

  logic [31:0]           wr_mask, wr_base, wr_merged, rd_data;
  logic [3:0]            reg_sel, wrap;
  logic                  wr_en, rd_en, phase_sync, status_clr, hold;
  logic [ACC_W:0]        sum;

  assign reg_sel = address[5:2];
  assign wr_en   = (data_write_n != 2'b11) && (address[1:0] == 2'b00);
  assign rd_en   = (data_read_n != 2'b11);

  // Bus writes merge new data into the selected register under the width mask.
  always_comb begin
    wr_mask    = 32'hFFFF_FFFF;
    wr_base    = 32'h0;
    ctrl_d     = ctrl_q;
    freq_d     = freq_q;
    phase_sync = 1'b0;
    status_clr = 1'b0;
    case (data_write_n)
      2'b00:   wr_mask = 32'h0000_00FF;
      2'b01:   wr_mask = 32'h0000_FFFF;
      default: wr_mask = 32'hFFFF_FFFF;
    endcase
    case (reg_sel)
      4'd0:    wr_base = 32'(ctrl_q);
      4'd1:    wr_base = 32'(freq_q[0]);
      4'd2:    wr_base = 32'(freq_q[1]);
      4'd3:    wr_base = 32'(freq_q[2]);
      4'd4:    wr_base = 32'(freq_q[3]);
      default: wr_base = 32'h0;
    endcase
    wr_merged = (wr_base & ~wr_mask) | (data_in & wr_mask);
    if (wr_en) begin
      case (reg_sel)
        4'd0: begin
          // phase_sync acts as a one-shot and is never stored
          ctrl_d     = wr_merged[10:0] & 11'h5FF;
          phase_sync = wr_merged[9];
        end
        4'd1, 4'd2, 4'd3, 4'd4: freq_d[2'(reg_sel - 4'd1)] = ACC_W'(wr_merged);
        4'd6:    status_clr = data_in[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    hold     = ctrl_q[10] & ui_in[0];
    acc_d    = acc_q;
    toggle_d = toggle_q;
    wrap     = 4'b0;
    sum      = '0;
    uo_lo_d  = 4'b0;
    for (int n = 0; n < 4; n++) begin
      sum = {1'b0, acc_q[n]} + {1'b0, freq_q[n]};
      if (phase_sync) begin
        acc_d[n]    = '0;
        toggle_d[n] = 1'b0;
      end else if (ctrl_q[n] && !hold) begin
        acc_d[n]    = sum[ACC_W-1:0];
        wrap[n]     = sum[ACC_W];
        toggle_d[n] = toggle_q[n] ^ sum[ACC_W];
      end
      uo_lo_d[n] = ctrl_q[n] & (acc_q[n][ACC_W-1] ^ ctrl_q[4+n]);
    end
    wrapcnt_d = wrapcnt_q + 16'(wrap[0]);
    pending_d = pending_q;
    if (status_clr) pending_d = 1'b0;
    if (ctrl_q[8] && wrap[0]) pending_d = 1'b1;
  end

  always_comb begin
    rd_data = 32'h0;
    if (address[1:0] == 2'b00) begin
      case (reg_sel)
        4'd0:    rd_data = 32'(ctrl_q);
        4'd1:    rd_data = 32'(freq_q[0]);
        4'd2:    rd_data = 32'(freq_q[1]);
        4'd3:    rd_data = 32'(freq_q[2]);
        4'd4:    rd_data = 32'(freq_q[3]);
        4'd5:    rd_data = 32'(acc_q[0]);
        4'd6:    rd_data = {31'h0, pending_q};
        4'd7:    rd_data = {16'h0, wrapcnt_q};
        default: rd_data = 32'h0;
      endcase
    end
    data_out_d   = rd_en ? rd_data : data_out_q;
    data_ready_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      freq_q       <= '0;
      acc_q        <= '0;
      toggle_q     <= '0;
      uo_lo_q      <= '0;
      wrapcnt_q    <= '0;
      pending_q    <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      freq_q       <= freq_d;
      acc_q        <= acc_d;
      toggle_q     <= toggle_d;
      uo_lo_q      <= uo_lo_d;
      wrapcnt_q    <= wrapcnt_d;
      pending_q    <= pending_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign uo_out         = {toggle_q, uo_lo_q};
  assign data_out       = data_out_q;
  assign data_ready     = data_ready_q;
  assign user_interrupt = pending_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, ui_in[7:1], wr_merged[31:11]};

endmodule

// File: tb/tb_tqvp_htfab_nco_quad.sv
// Self-checking bench: directed scenarios plus randomized bus traffic,
// compared every cycle against an arithmetic model of the peripheral.
module tb_tqvp_htfab_nco_quad;

  localparam int     ACC_W = 24;
  localparam longint MOD   = 64'd1 << ACC_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h0;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h0;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_htfab_nco_quad #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  logic [31:0] m_ctrl;
  longint      m_freq[4];
  longint      m_acc[4];
  logic [3:0]  m_tog, m_uo_lo;
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_dout;
  bit          m_dready;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    case (a[5:2])
      4'd0:    return m_ctrl;
      4'd1:    return 32'(m_freq[0]);
      4'd2:    return 32'(m_freq[1]);
      4'd3:    return 32'(m_freq[2]);
      4'd4:    return 32'(m_freq[3]);
      4'd5:    return 32'(m_acc[0]);
      4'd6:    return {31'h0, m_pend};
      4'd7:    return 32'(m_cnt);
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs that the edge sampled.
  task automatic model_step();
    logic [31:0] m, v, n_ctrl;
    longint n_freq[4];
    longint s;
    bit sync, clr, hold, wrap0;
    int idx;
    if (!rst_n) begin
      m_ctrl = 0; m_tog = 0; m_uo_lo = 0; m_cnt = 0; m_pend = 0;
      m_dout = 0; m_dready = 0;
      for (int n = 0; n < 4; n++) begin m_freq[n] = 0; m_acc[n] = 0; end
      return;
    end
    m = (data_write_n == 2'b00) ? 32'hFF : (data_write_n == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    sync = 0; clr = 0; wrap0 = 0;
    n_ctrl = m_ctrl;
    n_freq = m_freq;
    if (data_write_n != 2'b11 && address[1:0] == 2'b00) begin
      case (address[5:2])
        4'd0: begin
          v = (m_ctrl & ~m) | (data_in & m);
          sync = v[9];
          n_ctrl = v & 32'h5FF;
        end
        4'd1, 4'd2, 4'd3, 4'd4: begin
          idx = int'(address[5:2]) - 1;
          v = (32'(m_freq[idx]) & ~m) | (data_in & m);
          n_freq[idx] = longint'(v) % MOD;
        end
        4'd6: clr = data_in[0];
        default: ;
      endcase
    end
    if (data_read_n != 2'b11) begin
      m_dout = m_read(address);
      m_dready = 1;
    end else begin
      m_dready = 0;
    end
    for (int n = 0; n < 4; n++)
      m_uo_lo[n] = m_ctrl[n] ? ((m_acc[n] >= MOD / 2) ^ m_ctrl[4+n]) : 1'b0;
    hold = m_ctrl[10] && ui_in[0];
    for (int n = 0; n < 4; n++) begin
      if (sync) begin
        m_acc[n] = 0;
        m_tog[n] = 0;
      end else if (m_ctrl[n] && !hold) begin
        s = m_acc[n] + m_freq[n];
        if (s >= MOD) begin
          m_tog[n] = ~m_tog[n];
          if (n == 0) wrap0 = 1;
        end
        m_acc[n] = s % MOD;
      end
    end
    if (wrap0) m_cnt = (m_cnt + 1) % 65536;
    if (clr) m_pend = 0;
    if (m_ctrl[8] && wrap0) m_pend = 1;
    m_ctrl = n_ctrl;
    m_freq = n_freq;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] wn, input logic [1:0] rn,
                                input logic [5:0] a, input logic [31:0] d);
    data_write_n = wn;
    data_read_n  = rn;
    address      = a;
    data_in      = d;
    tick();
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    apply_stimulus(wn, 2'b11, a, d);
  endtask

  task automatic bus_read(input logic [5:0] a);
    apply_stimulus(2'b11, 2'b10, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Every settled cycle the DUT outputs must match the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("uo_out", 32'(uo_out), 32'({m_tog, m_uo_lo}));
      check_output("data_ready", 32'(data_ready), 32'(m_dready));
      check_output("data_out", data_out, m_dout);
      check_output("user_interrupt", 32'(user_interrupt), 32'(m_pend));
    end
  end

  initial begin
    int highs0, highs4, guard;
    logic [31:0] p1, p2, held;
    logic [5:0] a;
    logic [31:0] d;
    int r;

    // Reset held two cycles with strobes active.
    rst_n = 1'b0;
    data_write_n = 2'b10; data_read_n = 2'b10; address = 6'h00; data_in = 32'h0000_030F;
    tick();
    check_en = 1'b1;
    tick();
    data_write_n = 2'b11; data_read_n = 2'b11;
    check_output("reset_uo_out", 32'(uo_out), 32'h0);
    check_output("reset_data_ready", 32'(data_ready), 32'h0);
    check_output("reset_irq", 32'(user_interrupt), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(6'(i * 4));
      check_output("reset_readback", data_out, 32'h0);
      check_output("reset_read_ready", 32'(data_ready), 32'h1);
    end

    // Channel 0 at clk/4, wrap count after 40 cycles.
    bus_write(6'h04, 32'h0040_0000, 2'b10);
    bus_write(6'h00, 32'h0000_0001, 2'b10);
    idle(40);
    bus_read(6'h1C);
    check_output("wrapcnt0_after_40", data_out, 32'd10);
    highs0 = 0; highs4 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      highs0 += int'(uo_out[0]);
      highs4 += int'(uo_out[4]);
    end
    check_output("uo0_duty", 32'(highs0), 32'd4);
    check_output("uo4_duty", 32'(highs4), 32'd4);

    // Byte write merge and unaligned read.
    bus_write(6'h08, 32'h0012_3456, 2'b10);
    bus_write(6'h08, 32'h0000_00FF, 2'b00);
    bus_read(6'h08);
    check_output("freq1_byte_merge", data_out, 32'h0012_34FF);
    bus_read(6'h05);
    check_output("unaligned_read", data_out, 32'h0);
    check_output("unaligned_ready", 32'(data_ready), 32'h1);
    tick();
    check_output("ready_drops", 32'(data_ready), 32'h0);

    // Interrupt at clk/2 with clear racing a wrap.
    bus_write(6'h04, 32'h0080_0000, 2'b10);
    bus_write(6'h00, 32'h0000_0301, 2'b10);
    bus_read(6'h00);
    check_output("ctrl_sync_reads_0", data_out, 32'h0000_0101);
    guard = 0;
    while (!m_pend && guard < 10) begin tick(); guard++; end
    check_output("irq_rises", 32'(user_interrupt), 32'h1);
    guard = 0;
    while (m_acc[0] + m_freq[0] < MOD && guard < 10) begin tick(); guard++; end
    bus_write(6'h18, 32'h1, 2'b10);
    check_output("clear_on_wrap_loses", 32'(user_interrupt), 32'h1);
    bus_write(6'h18, 32'h1, 2'b10);
    check_output("clear_no_wrap", 32'(user_interrupt), 32'h0);

    // External hold freezes phase, release advances by FREQ0.
    bus_write(6'h10, 32'h0001_2345, 2'b10);
    bus_write(6'h14, 32'h00AB_CDEF, 2'b10);
    ui_in[0] = 1'b1;
    bus_write(6'h00, 32'h0000_040F, 2'b10);
    held = 32'(m_acc[0]);
    bus_read(6'h14);
    check_output("hold_phase_a", data_out, held);
    idle(3);
    bus_read(6'h14);
    check_output("hold_phase_b", data_out, held);
    ui_in[0] = 1'b0;
    bus_read(6'h14);
    p1 = data_out;
    bus_read(6'h14);
    p2 = data_out;
    check_output("phase_step", (p2 - p1) & 32'h00FF_FFFF, 32'h0080_0000);

    // Phase sync mid-run.
    idle(5);
    bus_write(6'h00, 32'h0000_020F, 2'b10);
    check_output("sync_toggles", 32'(uo_out[7:4]), 32'h0);
    bus_read(6'h14);
    check_output("sync_phase0", data_out, 32'h0);
    bus_read(6'h00);
    check_output("sync_ctrl", data_out, 32'h0000_000F);

    // Randomized traffic.
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 19) == 0) ui_in[0] = ~ui_in[0];
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) == 0) ? 6'($urandom) : {4'($urandom_range(0, 8)), 2'b00};
      if (r == 0) begin
        rst_n = 1'b0;
        apply_stimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a, $urandom);
        rst_n = 1'b1;
      end else if (r < 30) begin
        d = $urandom;
        if (a[5:2] == 4'd0) begin
          if ($urandom_range(0, 9) != 0) d[9] = 1'b0;
          if ($urandom_range(0, 1) == 1) d[3:0] = 4'hF;
        end else if (a[5:2] >= 4'd1 && a[5:2] <= 4'd4) begin
          case ($urandom_range(0, 3))
            0: d = 32'h0;
            1: d = 32'h0080_0000;
            2: d = 32'($urandom_range(1, 4096)) << 12;
            default: d = $urandom;
          endcase
        end
        bus_write(a, d, 2'($urandom_range(0, 2)));
      end else if (r < 55) begin
        apply_stimulus(2'b11, 2'($urandom_range(0, 2)), a, 32'h0);
      end else if (r < 58) begin
        apply_stimulus(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), a, $urandom & 32'hFFFF_FDFF);
      end else begin
        tick();
      end
    end

    idle(2);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
